// File: rtl/rb_pwm_pkg.sv
// Shared constants for the rb_pwm_dac PWM modulator: cfg word layout and frame length.
package rb_pwm_pkg;

  localparam int CFG_W         = 24;
  localparam int VAL_MSB       = 23;
  localparam int VAL_LSB       = 16;
  localparam int DIT_W         = 16;
  localparam int FRAME_PERIODS = 16;
  localparam int PIDX_W        = $clog2(FRAME_PERIODS);

  typedef logic [CFG_W-1:0] cfg_t;

endpackage

// File: rtl/rb_pwm_channel.sv
// One PWM channel: double-buffered duty/dither settings, compare and output register.
// Dither shift register exists only when RB_PWM_DITHER_EN is defined.
module rb_pwm_channel
  import rb_pwm_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [CW-1:0]    cnt_i,
  input  logic             per_end_i,
  input  logic             frm_end_i,
  input  logic [CFG_W-1:0] cfg_i,
  output logic             pwm_o
);

  localparam int VW = VAL_MSB - VAL_LSB + 1;
  localparam int EW = VW + 1;
  localparam int MW = (CW > EW) ? CW : EW;

  logic [VW-1:0] val_q, val_d;
  logic [EW-1:0] v_eff;
  logic          pwm_q, pwm_d;

  always_comb val_d = frm_end_i ? cfg_i[VAL_MSB:VAL_LSB] : val_q;

`ifdef RB_PWM_DITHER_EN
  logic [DIT_W-1:0] b_q, b_d;

  // Pattern is reloaded at frame end and consumed one bit per period, LSB first.
  always_comb begin
    b_d = b_q;
    if (frm_end_i) begin
      b_d = cfg_i[DIT_W-1:0];
    end else if (per_end_i) begin
      b_d = {1'b0, b_q[DIT_W-1:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      b_q <= '0;
    end else begin
      b_q <= b_d;
    end
  end

  assign v_eff = {1'b0, val_q} + EW'(b_q[0]);
`else
  logic unused_dit;
  assign unused_dit = ^{cfg_i[DIT_W-1:0], per_end_i};
  assign v_eff      = {1'b0, val_q};
`endif

  // A level of CCW+1 or more never loses the compare, so no clamp is needed.
  assign pwm_d = (MW'(cnt_i) < MW'(v_eff));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      val_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      val_q <= val_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/rb_pwm_dac.sv
// Four-channel PWM DAC: shared period/frame timebase feeding four rb_pwm_channel slices.
// Define RB_PWM_DITHER_EN to enable the 16-period dither pattern.
module rb_pwm_dac
  import rb_pwm_pkg::*;
#(
  parameter int CCW = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [23:0] cfg_a_i,
  input  logic [23:0] cfg_b_i,
  input  logic [23:0] cfg_c_i,
  input  logic [23:0] cfg_d_i,
  output logic [3:0]  pwm_o,
  output logic        frame_o
);

  localparam int CW = (CCW < 1) ? 1 : $clog2(CCW + 1);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PIDX_W-1:0] pidx_q, pidx_d;
  logic              frame_q;
  logic              per_end, frm_end;
  logic [CFG_W-1:0]  cfg_w [4];

  assign per_end = (cnt_q == CW'(CCW));
  assign frm_end = per_end && (pidx_q == PIDX_W'(FRAME_PERIODS - 1));

  always_comb begin
    cnt_d  = per_end ? '0 : cnt_q + 1'b1;
    pidx_d = per_end ? pidx_q + 1'b1 : pidx_q;
  end

  // Reset parks the timebase on the last cycle of a frame so the first
  // active edge captures cfg and starts a clean frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= CW'(CCW);
      pidx_q  <= PIDX_W'(FRAME_PERIODS - 1);
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pidx_q  <= pidx_d;
      frame_q <= frm_end;
    end
  end

  assign frame_o = frame_q;

  assign cfg_w[0] = cfg_a_i;
  assign cfg_w[1] = cfg_b_i;
  assign cfg_w[2] = cfg_c_i;
  assign cfg_w[3] = cfg_d_i;

  for (genvar g = 0; g < 4; g++) begin : g_ch
    rb_pwm_channel #(
      .CW (CW)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .cnt_i     (cnt_q),
      .per_end_i (per_end),
      .frm_end_i (frm_end),
      .cfg_i     (cfg_w[g]),
      .pwm_o     (pwm_o[g])
    );
  end

endmodule

// File: tb/tb_rb_pwm_dac.sv
// Self-checking bench for rb_pwm_dac: cycle scoreboard plus per-period/per-frame high counts.
// Expectations follow RB_PWM_DITHER_EN when it is defined for the build.
module tb_rb_pwm_dac;

  localparam int CCW   = 255;
  localparam int PER   = CCW + 1;
  localparam int FRAME = 16 * PER;
`ifdef RB_PWM_DITHER_EN
  localparam bit DITHER = 1'b1;
`else
  localparam bit DITHER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] cfg_a, cfg_b, cfg_c, cfg_d;
  logic [3:0]  pwm;
  logic        frame;

  always #5 clk = ~clk;

  rb_pwm_dac #(.CCW(CCW)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .cfg_a_i (cfg_a),
    .cfg_b_i (cfg_b),
    .cfg_c_i (cfg_c),
    .cfg_d_i (cfg_d),
    .pwm_o   (pwm),
    .frame_o (frame)
  );

  int checks = 0;
  int errors = 0;

  logic [4:0]  exp_q[$];
  int          m_cnt  = CCW;
  int          m_pidx = 15;
  logic [7:0]  m_val [4];
  logic [15:0] m_b   [4];

  int hi [4];
  int per_a, per_b;

  function automatic logic [23:0] cfg_of(int ch);
    case (ch)
      0:       return cfg_a;
      1:       return cfg_b;
      2:       return cfg_c;
      default: return cfg_d;
    endcase
  endfunction

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Behavioural model predicts the registered outputs for the coming edge.
  task automatic tick();
    logic [4:0]  e, got, want;
    logic [8:0]  ve;
    logic [23:0] c;
    logic        fe, pe;
    pe = (m_cnt == CCW);
    fe = pe && (m_pidx == 15);
    for (int ch = 0; ch < 4; ch++) begin
      ve    = {1'b0, m_val[ch]} + (DITHER ? {8'b0, m_b[ch][0]} : 9'd0);
      e[ch] = !rst && (m_cnt < int'(ve));
    end
    e[4] = !rst && fe;
    exp_q.push_back(e);
    if (rst) begin
      m_cnt  = CCW;
      m_pidx = 15;
      for (int ch = 0; ch < 4; ch++) begin
        m_val[ch] = '0;
        m_b[ch]   = '0;
      end
    end else begin
      for (int ch = 0; ch < 4; ch++) begin
        c = cfg_of(ch);
        if (fe) begin
          m_val[ch] = c[23:16];
          m_b[ch]   = c[15:0];
        end else if (pe) begin
          m_b[ch] = m_b[ch] >> 1;
        end
      end
      if (pe) m_pidx = (m_pidx + 1) % 16;
      m_cnt = pe ? 0 : m_cnt + 1;
    end
    @(posedge clk);
    #1;
    got  = {frame, pwm};
    want = exp_q.pop_front();
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL scoreboard {frame,pwm}: observed %b expected %b", got, want);
    end
    for (int ch = 0; ch < 4; ch++) hi[ch] += int'(pwm[ch]);
    per_a += int'(pwm[0]);
    per_b += int'(pwm[1]);
  endtask

  // Runs the 4096 cycles following a frame_o pulse and checks high counts.
  task automatic run_frame(string nm, int ea, int eb, int ec, int ed,
                           int a_pp, int b_p0, int b_p1,
                           int mid_step, logic [23:0] mid_d);
    int p;
    for (int ch = 0; ch < 4; ch++) hi[ch] = 0;
    per_a = 0;
    per_b = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (i == mid_step) cfg_d = mid_d;
      tick();
      if (i % PER == PER - 1) begin
        p = i / PER;
        chk($sformatf("%s A period %0d highs", nm, p), per_a, a_pp);
        chk($sformatf("%s B period %0d highs", nm, p), per_b, (p % 2 == 0) ? b_p0 : b_p1);
        per_a = 0;
        per_b = 0;
      end
    end
    chk({nm, " A frame highs"}, hi[0], ea);
    chk({nm, " B frame highs"}, hi[1], eb);
    chk({nm, " C frame highs"}, hi[2], ec);
    chk({nm, " D frame highs"}, hi[3], ed);
    chk({nm, " frame_o at 4096"}, int'(frame), 1);
  endtask

  initial begin
    int b_tot, b_p0, a3_pp, a3_tot, c3_tot;
    b_tot  = DITHER ? 1256 : 1248;
    b_p0   = DITHER ? 79 : 78;
    a3_pp  = DITHER ? 16 : 15;
    a3_tot = DITHER ? 256 : 240;
    c3_tot = DITHER ? 4096 : 4080;
    for (int ch = 0; ch < 4; ch++) begin
      m_val[ch] = '0;
      m_b[ch]   = '0;
      hi[ch]    = 0;
    end

    rst   = 1'b1;
    cfg_a = 24'h0;
    cfg_b = 24'h0;
    cfg_c = 24'h0;
    cfg_d = 24'h0;
    repeat (3) tick();
    checks++;
    assert ({frame, pwm} === 5'b0) else begin
      errors++;
      $error("FAIL reset outputs: observed %b expected 00000", {frame, pwm});
    end

    cfg_a = 24'h0F_0000;
    cfg_b = 24'h4E_5555;
    cfg_c = 24'h00_0000;
    cfg_d = 24'h9C_0000;
    rst   = 1'b0;
    tick();
    chk("frame_o after release", int'(frame), 1);
    chk("pwm_o on frame_o cycle", int'(pwm), 0);

    run_frame("F1", 240, b_tot, 0, 2496, 15, b_p0, 78, -1, 24'h0);

    // Written after capture: must wait for the end of F2.
    cfg_a = 24'h0F_FFFF;
    cfg_c = 24'hFF_FFFF;
    run_frame("F2", 240, b_tot, 0, 2496, 15, b_p0, 78, 7 * PER + 17, 24'h10_0000);

    run_frame("F3", a3_tot, b_tot, c3_tot, 256, a3_pp, b_p0, 78, -1, 24'h0);

    repeat (9 * PER + 40) tick();
    rst = 1'b1;
    tick();
    chk("mid-frame reset pwm_o", int'(pwm), 0);
    chk("mid-frame reset frame_o", int'(frame), 0);
    rst = 1'b0;
    tick();
    chk("frame_o after re-release", int'(frame), 1);

    run_frame("F4", a3_tot, b_tot, c3_tot, 256, a3_pp, b_p0, 78, -1, 24'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
